// File: rtl/calc_engine.sv
// -----------------------------------------------------------------------------
// calc_engine
//   Two-operand add/subtract calculator sequenced by an Enter key.
//   The operator enters A, then B (with the add/sub selection), the engine
//   computes for one cycle and then shows the result until the next Enter.
//   With CHAIN=1 the result becomes the next A (running-total mode).
//
// Parameters
//   WIDTH  operand/result width in bits (4..16)
//   CHAIN  0 = each result starts a fresh calculation, 1 = running total
//
// Ports
//   i_clock      single clock, rising edge
//   i_clear      synchronous active-low reset
//   i_enter      Enter key level (debounced); rising edge advances the FSM
//   i_key_data   operand value from the keypad unit
//   i_add_sub    0 = add, 1 = subtract; sampled when B is captured
//   o_disp_data  value for the display unit
//   o_disp_load  strobe: display unit latches o_disp_data
//   o_ovr        signed overflow of the last result
//   o_cout       carry-out (add) / no-borrow (subtract) of the last result
//   o_state      current FSM state, for debug
// -----------------------------------------------------------------------------
module calc_engine #(
    parameter int unsigned WIDTH = 8,
    parameter bit          CHAIN = 1'b0
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_enter,
    input  logic [WIDTH-1:0] i_key_data,
    input  logic             i_add_sub,
    output logic [WIDTH-1:0] o_disp_data,
    output logic             o_disp_load,
    output logic             o_ovr,
    output logic             o_cout,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        COMPUTE = 2'd2,
        RESULT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_enter_q;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic             r_op;
    logic             r_ovr;
    logic             r_cout;
    logic             r_disp_load;

    logic             w_edge;
    logic             w_load_next;
    logic [WIDTH-1:0] w_eff_b;
    logic [WIDTH:0]   w_sum;
    logic             w_ovr;

    assign w_edge = i_enter & ~r_enter_q;

    // Subtraction is A + ~B + 1; the +1 rides in as the low-order carry-in.
    assign w_eff_b = r_op ? ~r_b : r_b;
    assign w_sum   = {1'b0, r_a} + {1'b0, w_eff_b} + {{WIDTH{1'b0}}, r_op};
    assign w_ovr   = (r_a[WIDTH-1] == w_eff_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != r_a[WIDTH-1]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ENTER_A: if (w_edge) w_next = ENTER_B;
            ENTER_B: if (w_edge) w_next = COMPUTE;
            COMPUTE: w_next = RESULT;
            RESULT:  if (w_edge) w_next = CHAIN ? ENTER_B : ENTER_A;
            default: w_next = ENTER_A;
        endcase
    end

    // The load strobe is registered alongside the state so it lines up with
    // the cycle the new state is visible, and reads 0 in the first cycle
    // after reset even though the state is then ENTER_A.
    always_comb begin
        w_load_next = (w_next == ENTER_A) || (w_next == ENTER_B) ||
                      (w_next != r_state);
    end

    always_ff @(posedge i_clock) begin
        // Enter history follows the pin during reset so a key held through
        // reset release does not count as a press.
        r_enter_q <= i_enter;
        if (!i_clear) begin
            r_state     <= ENTER_A;
            r_a         <= '0;
            r_b         <= '0;
            r_r         <= '0;
            r_op        <= 1'b0;
            r_ovr       <= 1'b0;
            r_cout      <= 1'b0;
            r_disp_load <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_disp_load <= w_load_next;
            case (r_state)
                ENTER_A: begin
                    if (w_edge) r_a <= i_key_data;
                end
                ENTER_B: begin
                    if (w_edge) begin
                        r_b  <= i_key_data;
                        r_op <= i_add_sub;
                    end
                end
                COMPUTE: begin
                    r_r    <= w_sum[WIDTH-1:0];
                    r_cout <= w_sum[WIDTH];
                    r_ovr  <= w_ovr;
                end
                RESULT: begin
                    if (w_edge && CHAIN) r_a <= r_r;
                end
                default: ;
            endcase
        end
    end

    assign o_disp_data = ((r_state == ENTER_A) || (r_state == ENTER_B)) ? i_key_data : r_r;
    assign o_disp_load = r_disp_load;
    assign o_ovr       = r_ovr;
    assign o_cout      = r_cout;
    assign o_state     = r_state;

endmodule

// File: tb/tb_calc_engine.sv
module tb_calc_engine;

    logic        clk;
    logic        clear;
    logic        enter;
    logic        add_sub;
    logic [11:0] key;

    logic [7:0]  d8_data;
    logic        d8_load, d8_ovr, d8_cout;
    logic [1:0]  d8_state;
    logic [7:0]  dc_data;
    logic        dc_load, dc_ovr, dc_cout;
    logic [1:0]  dc_state;
    logic [11:0] d12_data;
    logic        d12_load, d12_ovr, d12_cout;
    logic [1:0]  d12_state;

    int checks;
    int errors;

    calc_engine #(.WIDTH(8), .CHAIN(1'b0)) dut8 (
        .i_clock(clk), .i_clear(clear), .i_enter(enter), .i_key_data(key[7:0]),
        .i_add_sub(add_sub), .o_disp_data(d8_data), .o_disp_load(d8_load),
        .o_ovr(d8_ovr), .o_cout(d8_cout), .o_state(d8_state)
    );

    calc_engine #(.WIDTH(8), .CHAIN(1'b1)) dutc (
        .i_clock(clk), .i_clear(clear), .i_enter(enter), .i_key_data(key[7:0]),
        .i_add_sub(add_sub), .o_disp_data(dc_data), .o_disp_load(dc_load),
        .o_ovr(dc_ovr), .o_cout(dc_cout), .o_state(dc_state)
    );

    calc_engine #(.WIDTH(12), .CHAIN(1'b0)) dut12 (
        .i_clock(clk), .i_clear(clear), .i_enter(enter), .i_key_data(key),
        .i_add_sub(add_sub), .o_disp_data(d12_data), .o_disp_load(d12_load),
        .o_ovr(d12_ovr), .o_cout(d12_cout), .o_state(d12_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular / signed integer arithmetic on the operands.
    task automatic model(input int unsigned a, input int unsigned b, input bit op,
                         input int w, output int unsigned r, output bit c, output bit v);
        int unsigned m;
        int unsigned full;
        int sa, sb, res;
        m    = 32'd1 << w;
        a    = a % m;
        b    = b % m;
        full = op ? (a + m - b) : (a + b);
        r    = full % m;
        c    = (full >= m);
        sa   = (a >= m / 2) ? int'(a) - int'(m) : int'(a);
        sb   = (b >= m / 2) ? int'(b) - int'(m) : int'(b);
        res  = op ? sa - sb : sa + sb;
        v    = (res > int'(m / 2) - 1) || (res < -int'(m / 2));
    endtask

    task automatic do_reset();
        clear = 1'b0;
        enter = 1'b0;
        step();
        step();
        clear = 1'b1;
        step();
    endtask

    // One full A/B/compute/result cycle on the CHAIN=0 instances.
    task automatic do_op(input logic [11:0] a, input logic [11:0] b, input bit op);
        int unsigned r8, r12;
        bit c8, v8, c12, v12;
        int n;
        model(a, b, op, 8, r8, c8, v8);
        model(a, b, op, 12, r12, c12, v12);

        key = a; enter = 1'b1; step(); enter = 1'b0; step();
        checks++;
        if (d8_state !== 2'd1 || d12_state !== 2'd1) begin
            errors++;
            $display("FAIL a_capture state got %0d/%0d want 1", d8_state, d12_state);
        end

        n = $urandom_range(0, 3);
        for (int i = 0; i <= n; i++) begin
            key = (i == n) ? b : 12'($urandom);
            #1;
            checks++;
            if (d8_data !== key[7:0] || d12_data !== key || d8_load !== 1'b1 || d12_load !== 1'b1) begin
                errors++;
                $display("FAIL echo_b got %h/%h load %b/%b want %h load 1", d8_data, d12_data, d8_load, d12_load, key);
            end
            step();
        end

        add_sub = op; enter = 1'b1; step();
        checks++;
        if (d8_state !== 2'd2 || d12_state !== 2'd2 || d8_load !== 1'b1 || d12_load !== 1'b1) begin
            errors++;
            $display("FAIL compute_entry state %0d/%0d load %b/%b want 2 load 1", d8_state, d12_state, d8_load, d12_load);
        end

        enter = 1'b0; add_sub = ~op; key = 12'($urandom); step();
        checks++;
        if (d8_state !== 2'd3 || d8_data !== 8'(r8) || d8_ovr !== v8 || d8_cout !== c8 || d8_load !== 1'b1) begin
            errors++;
            $display("FAIL result8 a=%h b=%h op=%0d got st=%0d r=%h v=%b c=%b ld=%b want st=3 r=%h v=%b c=%b ld=1",
                     a[7:0], b[7:0], op, d8_state, d8_data, d8_ovr, d8_cout, d8_load, 8'(r8), v8, c8);
        end
        checks++;
        if (d12_state !== 2'd3 || d12_data !== 12'(r12) || d12_ovr !== v12 || d12_cout !== c12 || d12_load !== 1'b1) begin
            errors++;
            $display("FAIL result12 a=%h b=%h op=%0d got st=%0d r=%h v=%b c=%b ld=%b want st=3 r=%h v=%b c=%b ld=1",
                     a, b, op, d12_state, d12_data, d12_ovr, d12_cout, d12_load, 12'(r12), v12, c12);
        end

        step();
        checks++;
        if (d8_state !== 2'd3 || d8_load !== 1'b0 || d12_load !== 1'b0 || d8_data !== 8'(r8)) begin
            errors++;
            $display("FAIL result_hold st=%0d ld=%b/%b r=%h want st=3 ld=0 r=%h", d8_state, d8_load, d12_load, d8_data, 8'(r8));
        end

        enter = 1'b1; step(); enter = 1'b0;
        checks++;
        if (d8_state !== 2'd0 || d12_state !== 2'd0 || d8_load !== 1'b1) begin
            errors++;
            $display("FAIL back_to_a st=%0d/%0d ld=%b want 0 ld 1", d8_state, d12_state, d8_load);
        end
        step();
        checks++;
        if (d8_ovr !== v8 || d8_cout !== c8 || d12_ovr !== v12 || d12_cout !== c12) begin
            errors++;
            $display("FAIL flags_hold got v=%b c=%b/v=%b c=%b want v=%b c=%b/v=%b c=%b",
                     d8_ovr, d8_cout, d12_ovr, d12_cout, v8, c8, v12, c12);
        end
    endtask

    task automatic test_reset();
        key = 12'h5A3; add_sub = 1'b0;
        clear = 1'b0; enter = 1'b1;
        step(); step();
        checks++;
        if (d8_state !== 2'd0 || dc_state !== 2'd0 || d12_state !== 2'd0 ||
            d8_ovr !== 1'b0 || d8_cout !== 1'b0 || d8_load !== 1'b0 || d12_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_state st=%0d/%0d/%0d ovr=%b cout=%b ld=%b want 0 0 0 0",
                     d8_state, dc_state, d12_state, d8_ovr, d8_cout, d8_load);
        end
        clear = 1'b1;
        step();
        checks++;
        if (d8_state !== 2'd0 || d8_load !== 1'b1 || d8_data !== key[7:0] || d12_data !== key) begin
            errors++;
            $display("FAIL release_held st=%0d ld=%b data=%h/%h want st=0 ld=1 data=%h", d8_state, d8_load, d8_data, d12_data, key);
        end
        repeat (3) step();
        checks++;
        if (d8_state !== 2'd0 || d12_state !== 2'd0 || dc_state !== 2'd0) begin
            errors++;
            $display("FAIL held_no_edge st=%0d/%0d/%0d want 0", d8_state, d12_state, dc_state);
        end
        enter = 1'b0; step();
        // Reset wins over a coincident Enter edge.
        clear = 1'b0; enter = 1'b1; step();
        clear = 1'b1; step();
        checks++;
        if (d8_state !== 2'd0 || d12_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_priority st=%0d/%0d want 0", d8_state, d12_state);
        end
        enter = 1'b0; step();
    endtask

    task automatic test_directed();
        do_reset();
        do_op(12'h005, 12'h003, 1'b0);
        do_op(12'h07F, 12'h001, 1'b0);
        do_op(12'h0FF, 12'h001, 1'b0);
        do_op(12'h080, 12'h001, 1'b1);
        do_op(12'h003, 12'h005, 1'b1);
        do_op(12'h7FF, 12'h001, 1'b0);
        do_op(12'h800, 12'h001, 1'b1);
        do_op(12'h000, 12'h000, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 25; i++)
            do_op(12'($urandom), 12'($urandom), 1'($urandom));
    endtask

    task automatic test_hold_and_clear();
        int trans;
        logic [1:0] prev;
        do_reset();
        do_op(12'h07F, 12'h001, 1'b0);
        key = 12'h07F; enter = 1'b1;
        trans = 0; prev = d8_state;
        for (int i = 0; i < 50; i++) begin
            step();
            if (d8_state != prev) trans++;
            prev = d8_state;
        end
        enter = 1'b0; step();
        checks++;
        if (trans !== 1 || d8_state !== 2'd1) begin
            errors++;
            $display("FAIL hold_50 transitions=%0d st=%0d want 1 st=1", trans, d8_state);
        end
        key = 12'h001; add_sub = 1'b0; enter = 1'b1; step();
        checks++;
        if (d8_state !== 2'd2) begin
            errors++;
            $display("FAIL reach_compute st=%0d want 2", d8_state);
        end
        clear = 1'b0; step();
        checks++;
        if (d8_state !== 2'd0 || d8_ovr !== 1'b0 || d8_cout !== 1'b0 || d8_load !== 1'b0 ||
            d12_state !== 2'd0 || d12_ovr !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_compute st=%0d ovr=%b cout=%b ld=%b want 0 0 0 0", d8_state, d8_ovr, d8_cout, d8_load);
        end
        clear = 1'b1; enter = 1'b0; step();
    endtask

    task automatic test_chain();
        int unsigned total, r;
        bit c, v;
        logic [7:0] b;
        bit op;
        do_reset();
        key = 12'd10; enter = 1'b1; step(); enter = 1'b0; step();
        total = 10;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin b = 8'd5; op = 1'b0; end
            else if (i == 1) begin b = 8'd20; op = 1'b0; end
            else begin b = 8'($urandom); op = 1'($urandom); end
            model(total, b, op, 8, r, c, v);
            checks++;
            if (dc_state !== 2'd1) begin
                errors++;
                $display("FAIL chain_enter_b st=%0d want 1", dc_state);
            end
            key = {4'h0, b}; add_sub = op; enter = 1'b1; step();
            enter = 1'b0; step();
            checks++;
            if (dc_state !== 2'd3 || dc_data !== 8'(r) || dc_ovr !== v || dc_cout !== c) begin
                errors++;
                $display("FAIL chain_result i=%0d got st=%0d r=%h v=%b c=%b want st=3 r=%h v=%b c=%b",
                         i, dc_state, dc_data, dc_ovr, dc_cout, 8'(r), v, c);
            end
            total = r;
            enter = 1'b1; step(); enter = 1'b0; step();
        end
        checks++;
        if (dc_state !== 2'd1) begin
            errors++;
            $display("FAIL chain_never_a st=%0d want 1", dc_state);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clear   = 1'b0;
        enter   = 1'b0;
        add_sub = 1'b0;
        key     = '0;
        test_reset();
        test_directed();
        test_random();
        test_hold_and_clear();
        test_chain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
